// File: rtl/fetch_buffer.sv
// Instruction fetch front end: issues one memory request at a time and buffers
// up to two {pc, instr} entries for decode, with flush/redirect handling.
module fetch_buffer (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    input  logic        flush,
    output logic [31:0] pc4,
    output logic        pc_en_n,
    output logic        imem_req_valid,
    output logic [31:0] imem_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DROP = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [1:0]  count_q, count_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [31:0] pc_mem_q    [2];
    logic [31:0] instr_mem_q [2];

    logic        req_fire_s;
    logic        push_s;
    logic        pop_s;

    // Request is only offered when no request is outstanding and a slot is free.
    always_comb begin
        imem_req_valid = ~rst & ~flush & (state_q == IDLE) & (count_q != 2'd2);
        req_fire_s     = imem_req_valid & imem_req_ready;
        pc_en_n        = ~req_fire_s;
        imem_addr      = pc_in;
        pc4            = pc_in + 32'd4;
        push_s         = ~rst & ~flush & (state_q == WAIT) & imem_rsp_valid;
        id_valid       = (count_q != 2'd0);
        pop_s          = id_valid & id_ready & ~flush;
        id_pc          = pc_mem_q[rd_ptr_q];
        id_instr       = instr_mem_q[rd_ptr_q];
        id_pc4         = pc_mem_q[rd_ptr_q] + 32'd4;
    end

    // Outstanding-request FSM; DROP swallows the response of a flushed request.
    always_comb begin
        state_d  = state_q;
        req_pc_d = req_pc_q;
        case (state_q)
            IDLE: begin
                if (req_fire_s) begin
                    state_d  = WAIT;
                    req_pc_d = pc_in;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (flush) begin
                    state_d = imem_rsp_valid ? IDLE : DROP;
                end else if (imem_rsp_valid) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT;
                end
            end
            DROP: begin
                if (flush) begin
                    state_d = DROP;
                end else if (imem_rsp_valid) begin
                    state_d = IDLE;
                end else begin
                    state_d = DROP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FIFO occupancy and pointers; flush empties the buffer outright.
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_d = ~wr_ptr_q;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = ~rd_ptr_q;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            req_pc_q <= 32'h0000_0000;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            req_pc_q <= req_pc_d;
        end
    end

    // Entry storage; contents are qualified by count so they need no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            pc_mem_q[wr_ptr_q]    <= req_pc_q;
            instr_mem_q[wr_ptr_q] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: a queue scoreboard holds expected decode
// entries and a negedge monitor checks every entry decode consumes.
module tb_fetch_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic        flush;
    logic [31:0] pc4;
    logic        pc_en_n;
    logic        imem_req_valid;
    logic [31:0] imem_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] sb_q [$];

    fetch_buffer dut (
        .clk            (clk),
        .rst            (rst),
        .pc_in          (pc_in),
        .flush          (flush),
        .pc4            (pc4),
        .pc_en_n        (pc_en_n),
        .imem_req_valid (imem_req_valid),
        .imem_addr      (imem_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rdata     (imem_rdata),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc4         (id_pc4)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // Monitor: every consumed head entry must match the oldest expected entry.
    always @(negedge clk) begin
        logic [63:0] e;
        logic [31:0] epc4;
        if (!rst && id_valid && id_ready && !flush) begin
            n_tests++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pop: got pc 0x%08h instr 0x%08h expected none", id_pc, id_instr);
            end else begin
                e    = sb_q.pop_front();
                epc4 = e[63:32] + 32'd4;
                if (id_pc !== e[63:32] || id_instr !== e[31:0] || id_pc4 !== epc4) begin
                    n_fail++;
                    $display("FAIL pop_entry: got pc 0x%08h instr 0x%08h pc4 0x%08h expected pc 0x%08h instr 0x%08h pc4 0x%08h",
                             id_pc, id_instr, id_pc4, e[63:32], e[31:0], epc4);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; pc_in = 32'h0; imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0; imem_rdata = 32'h0; id_ready = 1'b0;
        adv(); adv();
        // Reset state
        imem_req_ready = 1'b1;
        settle();
        check("rst_id_valid", {31'd0, id_valid}, 32'd0);
        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("rst_pc_en_n", {31'd0, pc_en_n}, 32'd1);
        adv();
        rst = 1'b0; imem_req_ready = 1'b0;

        // Basic fetch
        adv();
        pc_in = 32'h100; imem_req_ready = 1'b1;
        settle();
        check("basic_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("basic_addr", imem_addr, 32'h100);
        check("basic_pc4", pc4, 32'h104);
        check("basic_pc_en_n", {31'd0, pc_en_n}, 32'd0);
        adv();
        pc_in = 32'h104; imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1; imem_rdata = 32'h0050_0093;
        sb_q.push_back({32'h100, 32'h0050_0093});
        settle();
        check("wait_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("wait_pc_en_n", {31'd0, pc_en_n}, 32'd1);
        check("wait_id_valid", {31'd0, id_valid}, 32'd0);
        adv();
        imem_rsp_valid = 1'b0; id_ready = 1'b1;
        settle();
        check("basic_id_valid", {31'd0, id_valid}, 32'd1);
        check("basic_id_pc4", id_pc4, 32'h104);
        adv();
        id_ready = 1'b0;
        settle();
        check("basic_empty", {31'd0, id_valid}, 32'd0);

        // Backpressure with continuous ready and responses
        adv();
        pc_in = 32'h200; imem_req_ready = 1'b1; imem_rsp_valid = 1'b1; imem_rdata = 32'h9999_9999;
        settle();
        check("bp_accept0", {31'd0, pc_en_n}, 32'd0);
        adv();
        pc_in = 32'h204; imem_rdata = 32'h1111_1111;
        sb_q.push_back({32'h200, 32'h1111_1111});
        adv();
        imem_rdata = 32'h8888_8888;
        settle();
        check("bp_accept1", {31'd0, pc_en_n}, 32'd0);
        adv();
        pc_in = 32'h208; imem_rdata = 32'h2222_2222;
        sb_q.push_back({32'h204, 32'h2222_2222});
        for (int i = 0; i < 3; i++) begin
            adv();
            imem_rdata = 32'h7777_0000 + i;
            settle();
            check("bp_full_req_valid", {31'd0, imem_req_valid}, 32'd0);
            check("bp_full_pc_en_n", {31'd0, pc_en_n}, 32'd1);
            check("bp_full_id_valid", {31'd0, id_valid}, 32'd1);
            check("bp_full_head_pc", id_pc, 32'h200);
        end
        adv();
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; id_ready = 1'b1;
        adv();
        adv();
        id_ready = 1'b0;
        settle();
        check("bp_drained", {31'd0, id_valid}, 32'd0);

        // Flush in WAIT without response; late response must be dropped
        adv();
        pc_in = 32'h300; imem_req_ready = 1'b1;
        adv();
        flush = 1'b1; imem_req_ready = 1'b0;
        settle();
        check("fl_req_valid", {31'd0, imem_req_valid}, 32'd0);
        adv();
        flush = 1'b0; pc_in = 32'h400;
        settle();
        check("drop_req_valid", {31'd0, imem_req_valid}, 32'd0);
        adv();
        imem_rsp_valid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        settle();
        check("drop_id_valid", {31'd0, id_valid}, 32'd0);
        adv();
        imem_rsp_valid = 1'b0; imem_req_ready = 1'b1;
        settle();
        check("drop_after_id_valid", {31'd0, id_valid}, 32'd0);
        check("resume_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("resume_addr", imem_addr, 32'h400);
        check("resume_pc_en_n", {31'd0, pc_en_n}, 32'd0);
        adv();
        imem_req_ready = 1'b0; pc_in = 32'h404;
        imem_rsp_valid = 1'b1; imem_rdata = 32'h00A0_0113;
        sb_q.push_back({32'h400, 32'h00A0_0113});
        adv();
        imem_rsp_valid = 1'b0; id_ready = 1'b1;
        adv();
        id_ready = 1'b0;

        // Flush coinciding with response and pop
        pc_in = 32'h500; imem_req_ready = 1'b1;
        adv();
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rdata = 32'h1234_5678;
        sb_q.push_back({32'h500, 32'h1234_5678});
        adv();
        imem_rsp_valid = 1'b0; imem_req_ready = 1'b1; pc_in = 32'h504;
        adv();
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rdata = 32'hCAFE_F00D;
        flush = 1'b1; id_ready = 1'b1;
        sb_q.delete();
        settle();
        check("flpop_id_valid_before", {31'd0, id_valid}, 32'd1);
        adv();
        flush = 1'b0; imem_rsp_valid = 1'b0;
        settle();
        check("flpop_empty", {31'd0, id_valid}, 32'd0);
        check("flpop_idle_req", {31'd0, imem_req_valid}, 32'd1);
        adv();
        id_ready = 1'b0;

        // PC wrap-around
        pc_in = 32'hFFFF_FFFC; imem_req_ready = 1'b1;
        settle();
        check("wrap_pc4", pc4, 32'h0000_0000);
        adv();
        imem_req_ready = 1'b0; pc_in = 32'h0; imem_rsp_valid = 1'b1; imem_rdata = 32'h0000_0013;
        sb_q.push_back({32'hFFFF_FFFC, 32'h0000_0013});
        adv();
        imem_rsp_valid = 1'b0; id_ready = 1'b1;
        settle();
        check("wrap_id_pc4", id_pc4, 32'h0000_0000);
        adv();
        id_ready = 1'b0;

        // Reset in WAIT with one entry buffered
        pc_in = 32'h600; imem_req_ready = 1'b1;
        adv();
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rdata = 32'h0A0A_0A0A;
        adv();
        imem_rsp_valid = 1'b0; imem_req_ready = 1'b1; pc_in = 32'h604;
        settle();
        check("prerst_id_valid", {31'd0, id_valid}, 32'd1);
        adv();
        rst = 1'b1; imem_rsp_valid = 1'b1; imem_rdata = 32'hBBBB_BBBB;
        settle();
        check("inrst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("inrst_pc_en_n", {31'd0, pc_en_n}, 32'd1);
        adv();
        rst = 1'b0; imem_rsp_valid = 1'b0; imem_req_ready = 1'b0;
        settle();
        check("postrst_id_valid", {31'd0, id_valid}, 32'd0);
        check("postrst_req_valid", {31'd0, imem_req_valid}, 32'd1);
        adv();
        imem_rsp_valid = 1'b1; imem_rdata = 32'h5555_5555;
        settle();
        check("postrst_rsp_ignored", {31'd0, id_valid}, 32'd0);
        adv();
        imem_rsp_valid = 1'b0;
        settle();
        check("postrst_still_empty", {31'd0, id_valid}, 32'd0);

        // Resume after reset
        adv();
        pc_in = 32'h700; imem_req_ready = 1'b1;
        adv();
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rdata = 32'h7777_7777;
        sb_q.push_back({32'h700, 32'h7777_7777});
        adv();
        imem_rsp_valid = 1'b0; id_ready = 1'b1;
        adv();
        id_ready = 1'b0;
        adv();

        check("sb_empty_at_end", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 SHALL provide clk, input, 1: single clock; all state updates on rising edge.
REQ-002 SHALL provide rst, input, 1: reset, synchronous, active-high.
REQ-003 SHALL provide pc_in, input, 32: current fetch PC, driven by the PC register output.
REQ-004 SHALL provide flush, input, 1: branch/jump redirect; discard all fetched and in-flight instructions.
REQ-005 SHALL provide pc4, output, 32: pc_in + 4, the sequential next-PC fed back to the PC register.
REQ-006 SHALL provide pc_en_n, output, 1: active-low PC register enable; low only in a request-accept cycle.
REQ-007 SHALL provide imem_req_valid, output, 1: instruction memory request valid.
REQ-008 SHALL provide imem_addr, output, 32: request address, equal to pc_in.
REQ-009 SHALL provide imem_req_ready, input, 1: memory accepts the request this cycle.
REQ-010 SHALL provide imem_rsp_valid, input, 1: response data valid.
REQ-011 SHALL provide imem_rdata, input, 32: response instruction word.
REQ-012 SHALL provide id_valid, output, 1: head entry valid toward decode.
REQ-013 SHALL provide id_ready, input, 1: decode consumes the head entry this cycle.
REQ-014 SHALL provide id_instr, id_pc and id_pc4, outputs, 32 each: head instruction, its PC, and its PC + 4.

Function
REQ-015 SHALL hold a 2-entry FIFO of {pc, instr}, with 1-bit read/write pointers wrapping 1->0 and a 2-bit count (0..2).
REQ-016 SHALL run an FSM with states IDLE (no request outstanding), WAIT (one outstanding) and DROP (one outstanding, response to be discarded).
REQ-017 SHALL assert imem_req_valid only in IDLE with rst=0, flush=0 and count < 2; it is 0 in WAIT and DROP, so at most one request is ever outstanding.
REQ-018 SHALL, on imem_req_valid & imem_req_ready, latch pc_in as req_pc, drive pc_en_n=0 in that same cycle, and move IDLE->WAIT.
REQ-019 SHALL compute pc4 and id_pc4 modulo 2^32; 0xFFFFFFFC wraps to 0x00000000.
REQ-020 SHALL, in WAIT with imem_rsp_valid=1 and flush=0, write {req_pc, imem_rdata} at the write pointer and move to IDLE.
- Response earliest one cycle after accept.
- Pushed entry is visible on id_* the next cycle.
REQ-021 SHALL drive id_valid = (count != 0), with id_instr and id_pc taken from the read-pointer entry; a pop occurs on id_valid & id_ready & ~flush.
REQ-022 SHALL support push and pop in the same cycle; count is then unchanged and both pointers advance.
REQ-023 SHALL never push into a full FIFO; REQ-017 guarantees space is reserved before a request is issued.
REQ-024 SHALL, on flush=1, clear count and both pointers at the next edge, ignore any pop, and issue no request in that cycle.
- From WAIT with no response in the same cycle: go to DROP.
- From WAIT with a response in the same cycle: discard the data, go to IDLE.
- From IDLE or DROP: stay in the current state.
REQ-025 SHALL, in DROP, discard the response on imem_rsp_valid and move to IDLE; a flush in DROP keeps the FSM in DROP.
REQ-026 SHALL ignore imem_rsp_valid in IDLE.
REQ-027 SHALL drive pc_en_n=1 in every cycle without an accepted request, so the PC holds during stalls.

Reset
REQ-028 SHALL, while rst=1, set on the next edge: state IDLE, count 0, pointers 0, req_pc 0x00000000.
REQ-029 SHALL force imem_req_valid=0 and pc_en_n=1 combinationally while rst=1; id_valid=0 from the first edge with rst=1 until the first push.
REQ-030 SHALL let rst take priority over flush, push and pop; a response arriving in the reset cycle is discarded.

Verification
REQ-031 SHALL cover basic fetch: pc_in=0x100, ready=1, rdata=0x00500093 one cycle later -> pc_en_n=0 in the accept cycle; next cycle id_valid=1, id_pc=0x100, id_instr=0x00500093, id_pc4=0x104.
REQ-032 SHALL cover backpressure: id_ready=0, continuous ready/responses -> exactly two entries are buffered, imem_req_valid=0 while count=2, pc_en_n stays 1.
REQ-033 SHALL cover flush while in WAIT with no response: a later response with rdata=0xDEADBEEF is never presented (id_valid stays 0), FSM returns to IDLE and resumes fetching at the new pc_in.
REQ-034 SHALL cover flush coinciding with a response and a pop: buffer is empty the next cycle, the response data is dropped, and no pop is counted.
REQ-035 SHALL cover wrap-around: pc_in=0xFFFFFFFC -> pc4=0x00000000; the pushed entry has id_pc4=0x00000000.
REQ-036 SHALL cover reset mid-operation: rst in WAIT with count=1 -> next cycle id_valid=0, imem_req_valid=0 during rst, and a response in the reset cycle is dropped.
